// File: rtl/dma.sv
// dma: moves receiver FIFO bytes into RAM frames (with a completion flag) and
// streams RAM bytes to a transmitter, sharing the RAM bus granted by the CPU.
module dma #(
  parameter logic [7:0] RX_BASE      = 8'h00,
  parameter int         RX_LEN       = 3,
  parameter logic [7:0] RX_FLAG_ADDR = 8'h03,
  parameter logic [7:0] FLAG_VALUE   = 8'hFF,
  parameter logic [7:0] TX_BASE      = 8'h04,
  parameter int         TX_LEN       = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] RCVD_Data,
  input  logic       RX_Empty,
  input  logic       RX_Full,
  output logic       Data_Read,
  output logic [7:0] TX_Data,
  output logic       Valid_D,
  input  logic       Ack_out,
  input  logic       TX_RDY,
  output logic       DMA_Req,
  input  logic       DMA_Ack,
  input  logic       DMA_Tx_Start,
  output logic       DMA_Ready,
  output logic [7:0] Databus_Out,
  input  logic [7:0] Databus_In,
  output logic [7:0] RAM_Addr,
  output logic       RAM_Cs,
  output logic       RAM_Wen,
  output logic       RAM_Oen
);
  typedef enum logic [2:0] {
    IDLE, RX_REQ, RX_WRITE, RX_FLAG, TX_REQ, TX_READ, TX_SEND, TX_WAIT
  } state_t;

  state_t     r_state;
  logic [7:0] r_rx_cnt;
  logic [7:0] r_tx_cnt;
  logic [7:0] r_tx_byte;
  logic       r_tx_pending;
  logic       w_is_tx;
  logic       w_wr;
  logic       w_flag;
  logic       w_rd;
  logic       w_rx_last;
  logic       w_tx_last;
  logic       w_unused;

  assign w_unused = RX_Full;

  // Bus strobes are qualified by the live grant so nothing touches RAM without it.
  always_comb begin
    w_is_tx     = r_state inside {TX_REQ, TX_READ, TX_SEND, TX_WAIT};
    w_wr        = r_state == RX_WRITE && DMA_Ack && !RX_Empty;
    w_flag      = r_state == RX_FLAG && DMA_Ack;
    w_rd        = r_state == TX_READ && DMA_Ack;
    w_rx_last   = r_rx_cnt == 8'(RX_LEN - 1);
    w_tx_last   = r_tx_cnt == 8'(TX_LEN - 1);
    RAM_Cs      = w_wr || w_flag || w_rd;
    RAM_Wen     = w_wr || w_flag;
    RAM_Oen     = w_rd;
    RAM_Addr    = w_wr ? RX_BASE + r_rx_cnt : w_flag ? RX_FLAG_ADDR : w_rd ? TX_BASE + r_tx_cnt : 8'h00;
    Databus_Out = w_wr ? RCVD_Data : w_flag ? FLAG_VALUE : 8'h00;
    Data_Read   = w_wr;
    Valid_D     = (r_state == TX_SEND && TX_RDY) || r_state == TX_WAIT;
    TX_Data     = (r_state == TX_SEND || r_state == TX_WAIT) ? r_tx_byte : 8'h00;
    DMA_Req     = r_state inside {RX_REQ, RX_WRITE, RX_FLAG, TX_REQ, TX_READ};
    DMA_Ready   = r_state == IDLE && !r_tx_pending;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_rx_cnt     <= 8'h00;
      r_tx_cnt     <= 8'h00;
      r_tx_byte    <= 8'h00;
      r_tx_pending <= 1'b0;
    end else begin
      if (DMA_Tx_Start && !w_is_tx)
        r_tx_pending <= 1'b1;
      case (r_state)
        IDLE:
          if (r_tx_pending || DMA_Tx_Start)
            r_state <= TX_REQ;
          else if (!RX_Empty)
            r_state <= RX_REQ;
        RX_REQ:
          if (DMA_Ack)
            r_state <= RX_WRITE;
        RX_WRITE:
          if (w_wr) begin
            r_state  <= w_rx_last ? RX_FLAG : IDLE;
            r_rx_cnt <= w_rx_last ? r_rx_cnt : r_rx_cnt + 8'd1;
          end
        RX_FLAG:
          if (w_flag) begin
            r_state  <= IDLE;
            r_rx_cnt <= 8'h00;
          end
        TX_REQ:
          if (DMA_Ack)
            r_state <= TX_READ;
        TX_READ:
          if (w_rd) begin
            r_tx_byte <= Databus_In;
            r_state   <= TX_SEND;
          end
        TX_SEND:
          if (TX_RDY)
            r_state <= TX_WAIT;
        TX_WAIT:
          if (Ack_out) begin
            r_state  <= w_tx_last ? IDLE : TX_REQ;
            r_tx_cnt <= w_tx_last ? 8'h00 : r_tx_cnt + 8'd1;
            if (w_tx_last)
              r_tx_pending <= 1'b0;
          end
        default:
          r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dma.md
DMA -- requirements
Module: dma

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- RX_BASE, 8'h00, first RAM address for received bytes.
- RX_LEN, 3, number of received bytes per frame.
- RX_FLAG_ADDR, 8'h03, RAM address of the frame-complete flag.
- FLAG_VALUE, 8'hFF, value written to RX_FLAG_ADDR.
- TX_BASE, 8'h04, first RAM address of transmit bytes.
- TX_LEN, 2, number of bytes sent per DMA_Tx_Start.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- Clk, in, 1, single clock, rising edge.
- Rst_n, in, 1, reset; one clock; reset is asynchronous and active-low.
- RCVD_Data, in, 8, head byte of the receiver FIFO.
- RX_Empty, in, 1, receiver FIFO empty.
- RX_Full, in, 1, receiver FIFO full; informational only.
- Data_Read, out, 1, one-cycle pop of the receiver FIFO.
- TX_Data, out, 8, byte to the transmitter.
- Valid_D, out, 1, TX_Data valid.
- Ack_out, in, 1, transmitter accepted the byte.
- TX_RDY, in, 1, transmitter idle.
- DMA_Req, out, 1, bus request to the CPU.
- DMA_Ack, in, 1, bus grant from the CPU.
- DMA_Tx_Start, in, 1, one-cycle transmit command from the CPU.
- DMA_Ready, out, 1, DMA idle and no transmit pending.
- Databus_Out, out, 8, RAM write data.
- Databus_In, in, 8, RAM read data, combinational.
- RAM_Addr, out, 8, RAM address.
- RAM_Cs, out, 1, RAM chip select, active high.
- RAM_Wen, out, 1, RAM write strobe, active high.
- RAM_Oen, out, 1, RAM read enable, active high.

Function
REQ-003 The FSM SHALL have the states IDLE, RX_REQ, RX_WRITE, RX_FLAG, TX_REQ, TX_READ, TX_SEND and TX_WAIT.

REQ-004 A DMA_Tx_Start pulse seen in any state except TX_* SHALL set tx_pending; a pulse seen in a TX_* state SHALL be ignored.

REQ-005 In IDLE:
- If tx_pending=1 (or DMA_Tx_Start=1 this cycle), the next state SHALL be TX_REQ.
- Otherwise, if RX_Empty=0, the next state SHALL be RX_REQ.
- Transmit SHALL have priority over receive.

REQ-006 DMA_Ready SHALL be 1 only in IDLE with tx_pending=0, and 0 otherwise.

REQ-007 DMA_Req SHALL be 1 in RX_REQ, RX_WRITE, RX_FLAG, TX_REQ and TX_READ, and 0 in all other states.

REQ-008 RX_REQ and TX_REQ SHALL wait for DMA_Ack=1, then advance to RX_WRITE and TX_READ respectively.

REQ-009 RAM_Cs, RAM_Wen and RAM_Oen SHALL assert only in cycles where DMA_Ack=1; with DMA_Ack=0 the FSM holds its state with the strobes at 0.

REQ-010 RX_WRITE SHALL, in one cycle:
- drive RAM_Cs=1, RAM_Wen=1, RAM_Addr=RX_BASE+rx_cnt, Databus_Out=RCVD_Data and Data_Read=1;
- then, if rx_cnt=RX_LEN-1, go to RX_FLAG; else increment rx_cnt and return to IDLE, releasing the bus between bytes.

REQ-011 RX_FLAG SHALL, in one cycle, write FLAG_VALUE to RX_FLAG_ADDR, clear rx_cnt and return to IDLE.

REQ-012 TX_READ SHALL, in one cycle, drive RAM_Cs=1, RAM_Oen=1 and RAM_Addr=TX_BASE+tx_cnt, capture Databus_In into tx_byte at the clock edge, and go to TX_SEND.

REQ-013 TX_SEND SHALL wait for TX_RDY=1; in that cycle it SHALL assert Valid_D=1 with TX_Data=tx_byte and go to TX_WAIT.

REQ-014 TX_WAIT SHALL hold Valid_D=1 and TX_Data stable until Ack_out=1; Valid_D SHALL be 0 the cycle after Ack_out is seen.

REQ-015 On Ack_out in TX_WAIT:
- If tx_cnt=TX_LEN-1, the block SHALL clear tx_cnt and tx_pending and go to IDLE.
- Otherwise it SHALL increment tx_cnt and go to TX_REQ.

REQ-016 RAM_Addr SHALL be formed modulo 256 (8-bit wrap).

REQ-017 rx_cnt and tx_cnt SHALL never exceed LEN-1.

REQ-018 When not asserted, Databus_Out, RAM_Addr and TX_Data SHALL be 8'h00, except TX_Data in TX_SEND and TX_WAIT.

REQ-019 Data_Read SHALL never assert when RX_Empty=1.

REQ-020 A partial receive frame (rx_cnt>0) SHALL persist across interleaved transmits.

Reset
REQ-021 Rst_n=0 SHALL asynchronously:
- force state to IDLE;
- clear rx_cnt, tx_cnt, tx_pending and tx_byte;
- force DMA_Req, Data_Read, Valid_D, RAM_Cs, RAM_Wen and RAM_Oen to 0;
- force Databus_Out, RAM_Addr and TX_Data to 8'h00;
- force DMA_Ready to 1.

REQ-022 Reset asserted mid-frame SHALL discard the partial frame without writing the flag.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Scenario 1: FIFO supplies 8'h31, 8'h32, 8'h33 and the CPU grants each request -> RAM[0..2]=31,32,33; RAM[3]=FF; Data_Read pulses three times; rx_cnt=0 afterwards.
- Scenario 2: RAM[4]=8'hA5, RAM[5]=8'h5A; DMA_Tx_Start pulse; transmitter acknowledges 2 cycles after Valid_D -> TX_Data A5 then 5A; DMA_Ready=0 until the final Ack_out, then 1.
- Scenario 3: DMA_Tx_Start in the same cycle RX_Empty falls -> transmit runs first, then RX_REQ.
- Scenario 4: DMA_Ack held 0 for 5 cycles in RX_REQ -> DMA_Req stays 1; no RAM strobes and no Data_Read until the grant.
- Scenario 5: Rst_n pulsed low in TX_WAIT -> Valid_D=0 and DMA_Ready=1 immediately; no further Data_Read or Valid_D after release with RX_Empty=1.
- Scenario 6: DMA_Tx_Start pulsed during TX_WAIT -> ignored; exactly TX_LEN bytes sent.
